// File: rtl/shift_register_n_slot.sv
// Parametrised WIDTH x DEPTH shift register with hold/shift/rotate/load modes,
// fill tracking and a registered eviction port. Optional tap port: SHIFT_REG_TAP_EN.
module shift_register_n_slot #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_enable,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [WIDTH*DEPTH-1:0]   load_data,
`ifdef SHIFT_REG_TAP_EN
  input  logic [$clog2(DEPTH)-1:0] tap_sel,
  output logic [WIDTH-1:0]         tap_data,
`endif
  output logic [WIDTH*DEPTH-1:0]   data_out,
  output logic [WIDTH-1:0]         shift_out,
  output logic                     shift_out_valid,
  output logic [CNT_W-1:0]         count,
  output logic                     full
);

  localparam int unsigned BUS_W = WIDTH * DEPTH;
  localparam int unsigned LOW_W = WIDTH * (DEPTH - 1);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [BUS_W-1:0] data_nxt;
  logic [WIDTH-1:0] shift_out_nxt;
  logic             shift_out_valid_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] oldest;

  assign oldest = data_out[BUS_W-1 -: WIDTH];

  // Next-state selection; slot 0 sits in the low bits, oldest slot in the top bits
  always_comb begin
    data_nxt            = data_out;
    shift_out_nxt       = shift_out;
    shift_out_valid_nxt = 1'b0;
    count_nxt           = count;
    if (shift_enable) begin
      case (mode)
        MODE_HOLD: begin
          data_nxt = data_out;
        end
        MODE_SHIFT: begin
          data_nxt            = {data_out[LOW_W-1:0], data_in};
          shift_out_nxt       = oldest;
          shift_out_valid_nxt = (count == CNT_MAX);
          count_nxt           = (count == CNT_MAX) ? count : count + CNT_W'(1);
        end
        MODE_ROTATE: begin
          data_nxt = {data_out[LOW_W-1:0], oldest};
        end
        MODE_LOAD: begin
          data_nxt  = load_data;
          count_nxt = CNT_MAX;
        end
        default: begin
          data_nxt = data_out;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out        <= '0;
      shift_out       <= '0;
      shift_out_valid <= 1'b0;
      count           <= '0;
      full            <= 1'b0;
    end else begin
      data_out        <= data_nxt;
      shift_out       <= shift_out_nxt;
      shift_out_valid <= shift_out_valid_nxt;
      count           <= count_nxt;
      full            <= (count_nxt == CNT_MAX);
    end
  end

`ifdef SHIFT_REG_TAP_EN
  localparam int unsigned TAP_W = $clog2(DEPTH);

  logic [WIDTH-1:0] tap_nxt;

  // Out-of-range selects fall through to zero
  always_comb begin
    tap_nxt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (tap_sel == TAP_W'(k)) tap_nxt = data_nxt[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tap_data <= '0;
    else     tap_data <= tap_nxt;
  end
`endif

endmodule

// File: tb/tb_shift_register_n_slot.sv
// Directed self-checking bench for shift_register_n_slot at WIDTH=8, DEPTH=5.
module tb_shift_register_n_slot;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                   clk;
  logic                   rst;
  logic                   shift_enable;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       data_in;
  logic [WIDTH*DEPTH-1:0] load_data;
  logic [WIDTH*DEPTH-1:0] data_out;
  logic [WIDTH-1:0]       shift_out;
  logic                   shift_out_valid;
  logic [CNT_W-1:0]       count;
  logic                   full;
`ifdef SHIFT_REG_TAP_EN
  logic [$clog2(DEPTH)-1:0] tap_sel;
  logic [WIDTH-1:0]         tap_data;
`endif

  int n_checks;
  int n_fail;

  shift_register_n_slot #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .shift_enable    (shift_enable),
    .mode            (mode),
    .data_in         (data_in),
    .load_data       (load_data),
`ifdef SHIFT_REG_TAP_EN
    .tap_sel         (tap_sel),
    .tap_data        (tap_data),
`endif
    .data_out        (data_out),
    .shift_out       (shift_out),
    .shift_out_valid (shift_out_valid),
    .count           (count),
    .full            (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic en, input logic [1:0] m, input logic [WIDTH-1:0] d);
    shift_enable = en;
    mode         = m;
    data_in      = d;
    step();
  endtask

  task automatic check_idle_state(input string tag);
    check_eq({tag, "_data"},  64'(data_out), 64'h0);
    check_eq({tag, "_count"}, 64'(count), 64'd0);
    check_eq({tag, "_full"},  64'(full), 64'd0);
    check_eq({tag, "_sout"},  64'(shift_out), 64'h0);
    check_eq({tag, "_sov"},   64'(shift_out_valid), 64'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    shift_enable = 1'b0;
    mode         = 2'b00;
    data_in      = '0;
    load_data    = '0;
`ifdef SHIFT_REG_TAP_EN
    tap_sel      = 2;
`endif
    step();
    step();
    rst = 1'b0;
    check_idle_state("reset");

    // Fill with 1..5: evicted values are reset zeros, so no valid pulse
    for (int i = 1; i <= 5; i++) begin
      do_op(1'b1, 2'b01, 8'(i));
      check_eq($sformatf("fill_sov_%0d", i), 64'(shift_out_valid), 64'd0);
    end
    check_eq("fill_data",  64'(data_out), 64'h01_02_03_04_05);
    check_eq("fill_count", 64'(count), 64'd5);
    check_eq("fill_full",  64'(full), 64'd1);
`ifdef SHIFT_REG_TAP_EN
    check_eq("tap_slot2", 64'(tap_data), 64'h03);
`endif

    do_op(1'b1, 2'b01, 8'd6);
    check_eq("evict1_sov",  64'(shift_out_valid), 64'd1);
    check_eq("evict1_sout", 64'(shift_out), 64'h01);
    do_op(1'b1, 2'b01, 8'd7);
    check_eq("evict2_sov",  64'(shift_out_valid), 64'd1);
    check_eq("evict2_sout", 64'(shift_out), 64'h02);
    check_eq("evict2_data", 64'(data_out), 64'h03_04_05_06_07);

    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 2'b01, 8'd9);
      check_eq($sformatf("stall_data_%0d", i),  64'(data_out), 64'h03_04_05_06_07);
      check_eq($sformatf("stall_count_%0d", i), 64'(count), 64'd5);
      check_eq($sformatf("stall_sout_%0d", i),  64'(shift_out), 64'h02);
      check_eq($sformatf("stall_sov_%0d", i),   64'(shift_out_valid), 64'd0);
    end

    do_op(1'b1, 2'b10, 8'd9);
    check_eq("rot1_data",  64'(data_out), 64'h04_05_06_07_03);
    check_eq("rot1_sout",  64'(shift_out), 64'h02);
    check_eq("rot1_sov",   64'(shift_out_valid), 64'd0);
    for (int i = 0; i < 4; i++) do_op(1'b1, 2'b10, 8'd9);
    check_eq("rot5_data",  64'(data_out), 64'h03_04_05_06_07);
    check_eq("rot5_count", 64'(count), 64'd5);

    // Hold mode with enable high: no change, no pulse
    do_op(1'b1, 2'b01, 8'd8);
    check_eq("pre_hold_sov", 64'(shift_out_valid), 64'd1);
    do_op(1'b1, 2'b00, 8'd9);
    check_eq("hold_data", 64'(data_out), 64'h04_05_06_07_08);
    check_eq("hold_sov",  64'(shift_out_valid), 64'd0);
    check_eq("hold_sout", 64'(shift_out), 64'h03);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_state("reset2");
    do_op(1'b1, 2'b01, 8'hAA);
    do_op(1'b1, 2'b01, 8'hAA);
    check_eq("partial_count", 64'(count), 64'd2);
    check_eq("partial_full",  64'(full), 64'd0);
    load_data = 40'h14_13_12_11_10;
    do_op(1'b1, 2'b11, 8'h00);
    check_eq("load_data",  64'(data_out), 64'h14_13_12_11_10);
    check_eq("load_count", 64'(count), 64'd5);
    check_eq("load_full",  64'(full), 64'd1);
    check_eq("load_sov",   64'(shift_out_valid), 64'd0);
    check_eq("load_sout",  64'(shift_out), 64'h00);
    do_op(1'b1, 2'b01, 8'h55);
    check_eq("post_load_sout", 64'(shift_out), 64'h14);
    check_eq("post_load_sov",  64'(shift_out_valid), 64'd1);
    check_eq("post_load_data", 64'(data_out), 64'h13_12_11_10_55);

    // Reset wins over a simultaneous parallel load
    rst          = 1'b1;
    shift_enable = 1'b1;
    mode         = 2'b11;
    load_data    = 40'hFF_EE_DD_CC_BB;
    step();
    rst = 1'b0;
    check_idle_state("rst_load");
`ifdef SHIFT_REG_TAP_EN
    check_eq("rst_tap", 64'(tap_data), 64'h0);
`endif

    // After reset the count must refill before evictions are reported
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, 2'b01, 8'(8'h21 + i));
      check_eq($sformatf("refill_sov_%0d", i), 64'(shift_out_valid), 64'd0);
    end
    check_eq("refill_count", 64'(count), 64'd5);
    do_op(1'b1, 2'b01, 8'h26);
    check_eq("refill_evict_sov",  64'(shift_out_valid), 64'd1);
    check_eq("refill_evict_sout", 64'(shift_out), 64'h21);
    check_eq("refill_evict_data", 64'(data_out), 64'h22_23_24_25_26);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
